rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter sharing one resource among eight requesters. Produces a registered 3-bit grant index plus valid that drive the 3-to-8 decoder's `in`/`en` inputs directly, and an equivalent one-hot grant vector. Grants are held while the winner keeps requesting, capped at a hold limit. A one-cycle break-before-make gap separates consecutive grants.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles per tenure, range 1..255; 0 = unlimited.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input 8: level request per requester; bit i = requester i.
- `grant_vld` output 1: a grant is active; connects to decoder `en`.
- `grant_idx` output 3: index of current winner; connects to decoder `in`; 0 when `grant_vld`=0.
- `grant` output 8: one-hot of `grant_idx` when `grant_vld`=1, else 8'b0.
- `expire` output 1: one-cycle pulse in the cycle after a forced (hold-limit) release.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: `grant_vld`=1.
  - GAP: one dead cycle after every release.
- Rotating pointer `ptr` (3 bits). Arbitration scans `ptr`, `ptr+1`, … `ptr+7` mod 8. The first set `req` bit wins. The scan wraps 7→0.
- On entering GRANT with winner w:
  - `grant_idx`=w.
  - `ptr`←w+1 mod 8 (7 wraps to 0).
  - `hold_cnt`←1.
- IDLE → GRANT when `req`≠0; otherwise stay in IDLE.
- GRANT, per clock edge:
  - `req[grant_idx]`=0 → GAP (voluntary release, no `expire`).
  - else if `MAX_HOLD`≠0 and `hold_cnt`=`MAX_HOLD` → GAP, with `expire`=1 during the GAP cycle.
  - else stay in GRANT, `hold_cnt`+1.
- `hold_cnt` is 8 bits. It never wraps, because release occurs at `MAX_HOLD`. When `MAX_HOLD`=0 it saturates at 255 and is ignored.
- GAP → GRANT (new arbitration from the updated `ptr`) if `req`≠0; otherwise GAP → IDLE.
  - A released requester still requesting is therefore served only after every other active requester ahead of it in rotation.
- Requests that appear or disappear during GRANT do not affect the current tenure; only `req[grant_idx]` matters.
- Reset (`rst_n`=0, any time, including mid-grant) immediately forces:
  - state IDLE, `ptr`=0, `hold_cnt`=0;
  - `grant_vld`=0, `grant_idx`=0, `grant`=0, `expire`=0.
- After reset release, the first arbitration starts at index 0.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- Grant latency: `req` sampled high at edge k in IDLE → `grant_vld`=1 from edge k (visible in the cycle after the edge) until the release edge.
- Forced-release tenure: exactly `MAX_HOLD` cycles of `grant_vld`=1, then exactly 1 cycle of `grant_vld`=0 (GAP), then the next grant if requests are pending.
- Voluntary release: `req[grant_idx]` seen low at edge k → `grant_vld`=0 after edge k; the next grant can appear after edge k+1.
- Throughput with continuous requests: one grant per `MAX_HOLD`+1 cycles.
- `expire` is high exactly for the GAP cycle following a hold-limit release.

## Configuration
- `RR_ARB_PRIO0_EN` defined: requester 0 is high-priority.
  - In IDLE and GAP arbitration, `req[0]`=1 wins regardless of `ptr`, and `ptr` is not updated by a requester-0 grant.
  - A requester-0 tenure ignores `MAX_HOLD`; it ends only on voluntary release, so `expire` is never raised for it.
  - No preemption: an ongoing grant to another requester completes normally.
- Not defined: pure round-robin; requester 0 is treated like all others.

## Test plan
- Reset: assert `rst_n`=0 with `req`=8'hFF → `grant_vld`=0, `grant_idx`=0, `grant`=8'h00, `expire`=0; release reset → first grant to idx 0.
- Single requester: `req`=8'b0010_0000 held, `MAX_HOLD`=16 → `grant_idx`=5, `grant`=8'b0010_0000 for 16 cycles, 1 GAP cycle with `expire`=1, then idx 5 granted again.
- All request: `req`=8'hFF held → grant order 0,1,2,…,7,0, each tenure 16 cycles, separated by 1-cycle gaps.
- Wrap-around: last grant to idx 6 (`ptr`=7), then `req`=8'b0100_0100 → idx 2 granted before idx 6.
- Voluntary release and reset mid-operation: drop `req[3]` after 3 grant cycles → `grant_vld`=0 next cycle, `expire`=0. In a separate run, pulse `rst_n` low mid-grant → outputs 0 immediately and next arbitration starts at idx 0.
- Macro build (`RR_ARB_PRIO0_EN`): `ptr`=1, `req`=8'b0001_0001 → idx 0 wins and is held for 40 cycles without `expire`. Dropping `req[0]` → idx 4 granted after the GAP cycle.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with hold limit and a one-cycle
// break-before-make gap between consecutive grants.
// Optional feature macro: RR_ARB_PRIO0_EN (requester 0 becomes high-priority,
// never moves the rotation pointer, and is exempt from the hold limit).
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic       grant_vld,
    output logic [2:0] grant_idx,
    output logic [7:0] grant,
    output logic       expire
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         LIMIT_ON   = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     r_state, w_stateNext;
    logic [2:0] r_ptr, w_ptrNext;
    logic [7:0] r_hold, w_holdNext;
    logic [2:0] r_idx, w_idxNext;
    logic [7:0] r_grant, w_grantNext;
    logic       r_expire, w_expireNext;

    logic [2:0] w_winner;
    logic       w_found;
    logic       w_winnerIsPrio;
    logic       w_limitApplies;

    // Scan the requests starting at the rotation pointer; first set bit wins
    always_comb begin
        logic [2:0] cand;
        w_winner       = 3'd0;
        w_found        = 1'b0;
        w_winnerIsPrio = 1'b0;
        cand           = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = r_ptr + 3'(k);
            if (!w_found && req[cand]) begin
                w_winner = cand;
                w_found  = 1'b1;
            end
        end
`ifdef RR_ARB_PRIO0_EN
        if (req[0]) begin
            w_winner       = 3'd0;
            w_winnerIsPrio = 1'b1;
        end
`endif
    end

    // The hold limit applies to every tenure except a high-priority one
    always_comb begin
`ifdef RR_ARB_PRIO0_EN
        w_limitApplies = LIMIT_ON && (r_idx != 3'd0);
`else
        w_limitApplies = LIMIT_ON;
`endif
    end

    // Next-state and next-output logic; outputs are registered from these
    always_comb begin
        w_stateNext  = r_state;
        w_ptrNext    = r_ptr;
        w_holdNext   = r_hold;
        w_idxNext    = r_idx;
        w_grantNext  = r_grant;
        w_expireNext = 1'b0;
        unique case (r_state)
            IDLE, GAP: begin
                if (w_found) begin
                    w_stateNext = GRANT;
                    w_idxNext   = w_winner;
                    w_grantNext = 8'(1) << w_winner;
                    w_holdNext  = 8'd1;
                    if (!w_winnerIsPrio) begin
                        w_ptrNext = w_winner + 3'd1;
                    end
                end else begin
                    w_stateNext = IDLE;
                    w_idxNext   = 3'd0;
                    w_grantNext = 8'h00;
                end
            end
            GRANT: begin
                if (!req[r_idx]) begin
                    w_stateNext = GAP;
                    w_idxNext   = 3'd0;
                    w_grantNext = 8'h00;
                end else if (w_limitApplies && (r_hold == HOLD_LIMIT)) begin
                    w_stateNext  = GAP;
                    w_idxNext    = 3'd0;
                    w_grantNext  = 8'h00;
                    w_expireNext = 1'b1;
                end else if (r_hold != 8'hFF) begin
                    w_holdNext = r_hold + 8'd1;
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_idxNext   = 3'd0;
                w_grantNext = 8'h00;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= 3'd0;
            r_hold   <= 8'd0;
            r_idx    <= 3'd0;
            r_grant  <= 8'h00;
            r_expire <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_ptr    <= w_ptrNext;
            r_hold   <= w_holdNext;
            r_idx    <= w_idxNext;
            r_grant  <= w_grantNext;
            r_expire <= w_expireNext;
        end
    end

    assign grant_vld = (r_state == GRANT);
    assign grant_idx = r_idx;
    assign grant     = r_grant;
    assign expire    = r_expire;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: a cycle-level reference model predicts the
// outputs after every clock edge and queues them; a monitor on the falling
// edge pops each prediction and compares it against the DUT.
module tb_rr_arbiter8;

    localparam int MAXH = 16;
`ifdef RR_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef struct packed {
        logic       vld;
        logic [2:0] idx;
        logic [7:0] gnt;
        logic       exp;
    } expect_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       grant_vld;
    logic [2:0] grant_idx;
    logic [7:0] grant;
    logic       expire;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;
    expect_t expQ[$];

    // Reference model state: current owner (-1 = nobody), cycles held, pointer
    int mOwner = -1;
    int mHeld  = 0;
    int mPtr   = 0;
    bit mExpire = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx),
        .grant     (grant),
        .expire    (expire)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pickWinner(input logic [7:0] r, input int start);
        if (PRIO0 && r[0]) return 0;
        for (int k = 0; k < 8; k++) begin
            if (r[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic expect_t modelOutputs();
        expect_t e;
        e.vld = (mOwner >= 0);
        e.idx = (mOwner >= 0) ? 3'(mOwner) : 3'd0;
        e.gnt = (mOwner >= 0) ? (8'd1 << mOwner) : 8'h00;
        e.exp = mExpire;
        return e;
    endfunction

    // Reference model: advance one cycle per edge, reset clears everything
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mOwner  = -1;
            mHeld   = 0;
            mPtr    = 0;
            mExpire = 1'b0;
            if (!clk || $time == 0 || started) expQ.delete();
            expQ.push_back(modelOutputs());
            started = 1'b1;
        end else begin
            bit nextExp;
            int w;
            nextExp = 1'b0;
            if (mOwner >= 0) begin
                if (!req[mOwner]) begin
                    mOwner = -1;
                end else if (MAXH != 0 && !(PRIO0 && mOwner == 0) && mHeld == MAXH) begin
                    mOwner  = -1;
                    nextExp = 1'b1;
                end else if (mHeld < 255) begin
                    mHeld++;
                end
            end else begin
                w = pickWinner(req, mPtr);
                if (w >= 0) begin
                    mOwner = w;
                    mHeld  = 1;
                    if (!(PRIO0 && w == 0)) mPtr = (w + 1) % 8;
                end
            end
            mExpire = nextExp;
            expQ.push_back(modelOutputs());
            started = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, required);
        end
    endtask

    // Monitor: compare every cycle's outputs against the oldest prediction
    always @(negedge clk) begin
        if (started) begin
            if (expQ.size() == 0) begin
                checkOutput("queue_underflow", 0, 1);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("grant_vld", int'(grant_vld), int'(e.vld));
                checkOutput("grant_idx", int'(grant_idx), int'(e.idx));
                checkOutput("grant", int'(grant), int'(e.gnt));
                checkOutput("expire", int'(expire), int'(e.exp));
            end
        end
    end

    // Hold a request pattern for a number of cycles, changing just after the edge
    task automatic applyStimulus(input logic [7:0] r, input int cycles);
        req = r;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic pulseReset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        $display("[TB] reset released, all requesting");

        // Full rotation with every requester active, forced releases throughout
        applyStimulus(8'hFF, 9 * (MAXH + 1) + 5);

        // Single requester repeatedly hitting the hold limit
        pulseReset(2);
        applyStimulus(8'h20, 3 * (MAXH + 1) + 4);

        // Wrap-around: idx 6 owns, then idx 2 must be served before idx 6 again
        applyStimulus(8'h00, 4);
        pulseReset(2);
        applyStimulus(8'h40, 5);
        applyStimulus(8'h44, 3 * (MAXH + 1) + 4);

        // Voluntary release after three grant cycles
        applyStimulus(8'h00, 4);
        applyStimulus(8'h08, 4);
        applyStimulus(8'h00, 4);

        // Reset in the middle of a tenure, then arbitration restarts from 0
        applyStimulus(8'h90, 6);
        pulseReset(2);
        applyStimulus(8'hFF, 2 * (MAXH + 1) + 3);

        // Requester 0 together with another; with priority it holds past the limit
        applyStimulus(8'h00, 3);
        applyStimulus(8'h11, 40);
        applyStimulus(8'h10, 6);

        // Randomized requests with occasional pattern changes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 8'($urandom);
                    1: req = 8'($urandom & $urandom);
                    2: req = 8'd1 << $urandom_range(0, 7);
                    default: req = 8'h00;
                endcase
            end
            @(posedge clk);
            #2;
            if ($urandom_range(0, 999) == 0) pulseReset(1);
        end

        applyStimulus(8'h00, 3);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
